// File: rtl/i3c_axi_sub_reg_bridge.sv
// Bridges single-beat component accesses onto a req/ack register-window bus.
// The upstream is held while a request is in flight; each request is bounded by a timeout.
module i3c_axi_sub_reg_bridge #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int UW = 32,
    parameter int IW = 1,
    parameter logic [AW-1:0] BASE_ADDR = '0,
    parameter int WIN_SIZE = 4096,
    parameter int TIMEOUT = 256,
    localparam int BC = DW / 8,
    localparam int RAW = $clog2(WIN_SIZE) - $clog2(BC)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           dv,
    input  logic [AW-1:0]  addr,
    input  logic           write,
    input  logic [UW-1:0]  user,
    input  logic [IW-1:0]  id,
    input  logic [DW-1:0]  wdata,
    input  logic [BC-1:0]  wstrb,
    input  logic [2:0]     size,
    input  logic           last,
    output logic           hld,
    output logic [DW-1:0]  rdata,
    output logic           rd_err,
    output logic           wr_err,
    output logic           req,
    output logic           req_we,
    output logic [RAW-1:0] req_addr,
    output logic [DW-1:0]  req_wdata,
    output logic [BC-1:0]  req_wstrb,
    output logic [UW-1:0]  req_user,
    input  logic           ack,
    input  logic [DW-1:0]  ack_rdata,
    input  logic           ack_err,
    output logic           timeout_evt
);

    localparam int WB = $clog2(WIN_SIZE);
    localparam int OB = $clog2(BC);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic TO_EN = (TIMEOUT != 0);
    // Counter holds completed REQ cycles, so the last allowed cycle sees TIMEOUT-1.
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            req_we_q, req_we_d;
    logic [RAW-1:0]  req_addr_q, req_addr_d;
    logic [DW-1:0]   req_wdata_q, req_wdata_d;
    logic [BC-1:0]   req_wstrb_q, req_wstrb_d;
    logic [UW-1:0]   req_user_q, req_user_d;
    logic [DW-1:0]   data_q, data_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic in_range;
    logic start;
    logic to_hit;
    logic unused_ok;

    assign in_range  = (addr[AW-1:WB] == BASE_ADDR[AW-1:WB]);
    assign start     = (state_q == IDLE) && dv && in_range;
    assign to_hit    = TO_EN && (cnt_q == TO_LAST);
    assign unused_ok = ^{id, size, last, addr[OB-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = REQ;
            REQ:     if (ack || to_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hld         = 1'b0;
        req         = 1'b0;
        rdata       = '0;
        rd_err      = 1'b0;
        wr_err      = 1'b0;
        timeout_evt = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (dv) begin
                    if (in_range) begin
                        hld = 1'b1;
                    end else begin
                        rd_err = !write;
                        wr_err = write;
                    end
                end
            end
            REQ: begin
                req         = 1'b1;
                hld         = 1'b1;
                timeout_evt = !ack && to_hit;
            end
            RESP: begin
                rdata  = data_q;
                rd_err = err_q & ~req_we_q;
                wr_err = err_q & req_we_q;
            end
            default: begin
                hld = 1'b0;
            end
        endcase
    end

    // Request fields are captured once at launch and never re-sampled.
    always_comb begin
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_wstrb_d = req_wstrb_q;
        req_user_d  = req_user_q;
        data_d      = data_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        if (start) begin
            req_we_d    = write;
            req_addr_d  = addr[WB-1:OB];
            req_wdata_d = wdata;
            req_wstrb_d = wstrb;
            req_user_d  = user;
            cnt_d       = '0;
        end else if (state_q == REQ) begin
            if (cnt_q != {CW{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (ack) begin
                data_d = req_we_q ? '0 : ack_rdata;
                err_d  = ack_err;
            end else if (to_hit) begin
                data_d = '0;
                err_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wstrb_q <= '0;
            req_user_q  <= '0;
            data_q      <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_wstrb_q <= req_wstrb_d;
            req_user_q  <= req_user_d;
            data_q      <= data_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign req_we    = req_we_q;
    assign req_addr  = req_addr_q;
    assign req_wdata = req_wdata_q;
    assign req_wstrb = req_wstrb_q;
    assign req_user  = req_user_q;

endmodule

// File: tb/tb_i3c_axi_sub_reg_bridge.sv
// Directed and randomized checks of i3c_axi_sub_reg_bridge against a per-access
// latency/result model derived from window range, ack cycle and timeout rules.
module tb_i3c_axi_sub_reg_bridge;

    localparam int          TO   = 4;
    localparam int          WIN  = 4096;
    localparam logic [31:0] BASE = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dv;
    logic [31:0] addr;
    logic        write;
    logic [31:0] user;
    logic [0:0]  id;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [2:0]  size;
    logic        last;
    logic        hld;
    logic [31:0] rdata;
    logic        rd_err;
    logic        wr_err;
    logic        req;
    logic        req_we;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic [31:0] req_user;
    logic        ack;
    logic [31:0] ack_rdata;
    logic        ack_err;
    logic        timeout_evt;

    int n_vec = 0;
    int n_err = 0;

    i3c_axi_sub_reg_bridge #(
        .BASE_ADDR(BASE),
        .WIN_SIZE (WIN),
        .TIMEOUT  (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dv         (dv),
        .addr       (addr),
        .write      (write),
        .user       (user),
        .id         (id),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .size       (size),
        .last       (last),
        .hld        (hld),
        .rdata      (rdata),
        .rd_err     (rd_err),
        .wr_err     (wr_err),
        .req        (req),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .req_user   (req_user),
        .ack        (ack),
        .ack_rdata  (ack_rdata),
        .ack_err    (ack_err),
        .timeout_evt(timeout_evt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the edge ending the completion cycle.
    // ack_cyc = cycle in which ack is driven (0 = never).
    task automatic access(input logic [31:0] a, input logic w, input logic [31:0] wd,
                          input logic [3:0] ws, input logic [31:0] u, input int ack_cyc,
                          input logic [31:0] ard, input logic aerr);
        bit          inr;
        bit          to_exp;
        int          done;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [31:0] exp_waddr;
        inr       = ((a / WIN) == (BASE / WIN));
        exp_waddr = ((a - BASE) % WIN) / 4;
        to_exp    = 1'b0;
        if (!inr) begin
            done      = 0;
            exp_rdata = 32'h0;
            exp_err   = 1'b1;
        end else if (ack_cyc >= 1 && ack_cyc <= TO) begin
            done      = ack_cyc + 1;
            exp_rdata = w ? 32'h0 : ard;
            exp_err   = aerr;
        end else begin
            done      = TO + 1;
            to_exp    = 1'b1;
            exp_rdata = 32'h0;
            exp_err   = 1'b1;
        end
        $display("access addr=%08h we=%0d ack_cyc=%0d -> done=%0d rdata=%08h err=%0d to=%0d",
                 a, w, ack_cyc, done, exp_rdata, exp_err, to_exp);
        dv = 1'b1; addr = a; write = w; wdata = wd; wstrb = ws; user = u;
        for (int c = 0; c <= done; c++) begin
            ack       = (c == ack_cyc) && (ack_cyc != 0);
            ack_rdata = ard;
            ack_err   = aerr;
            @(negedge clk);
            check("hld", hld, (c != done));
            check("req", req, (c >= 1 && c < done));
            check("timeout_evt", timeout_evt, (to_exp && c == TO));
            if (c >= 1 && c < done) begin
                check("req_addr", req_addr, exp_waddr[9:0]);
                check("req_we", req_we, w);
                check("req_wdata", req_wdata, wd);
                check("req_wstrb", req_wstrb, ws);
                check("req_user", req_user, u);
            end
            if (c == done) begin
                check("rdata", rdata, exp_rdata);
                check("rd_err", rd_err, exp_err && !w);
                check("wr_err", wr_err, exp_err && w);
            end else begin
                check("rdata_idle", rdata, 32'h0);
            end
            @(posedge clk); #1;
        end
        dv = 1'b0; ack = 1'b0; ack_err = 1'b0;
    endtask

    // One idle cycle with a stray ack that must have no effect.
    task automatic stray_ack(input logic [31:0] ard);
        ack = 1'b1; ack_rdata = ard; ack_err = 1'b1;
        @(negedge clk);
        check("stray_req", req, 1'b0);
        check("stray_hld", hld, 1'b0);
        check("stray_rdata", rdata, 32'h0);
        check("stray_err", {rd_err, wr_err, timeout_evt}, 3'b000);
        @(posedge clk); #1;
        ack = 1'b0; ack_err = 1'b0;
        @(negedge clk);
        check("stray_after_hld", hld, 1'b0);
        check("stray_after_rdata", rdata, 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] a, d;
        rst_n = 1'b0; dv = 1'b0; addr = '0; write = 1'b0; user = '0; id = '0;
        wdata = '0; wstrb = '0; size = 3'd2; last = 1'b1;
        ack = 1'b0; ack_rdata = '0; ack_err = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", req, 1'b0);
        check("rst_hld", hld, 1'b0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_req_fields", {req_we, req_addr, req_wdata, req_wstrb, req_user} == '0, 1'b1);
        check("rst_evt", timeout_evt, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        access(BASE + 32'h10, 1'b0, 32'h1111_2222, 4'hF, 32'h0000_00AA, 3, 32'hDEAD_BEEF, 1'b0);
        access(BASE + 32'hFFC, 1'b1, 32'hA5A5_A5A5, 4'h3, 32'h0000_0055, 1, 32'h1234_5678, 1'b1);
        access(BASE + 32'h1000, 1'b0, 32'h0, 4'hF, 32'h0, 1, 32'hFFFF_FFFF, 1'b0);
        access(BASE - 32'h4, 1'b1, 32'h0, 4'hF, 32'h0, 1, 32'hFFFF_FFFF, 1'b0);
        access(BASE + 32'h20, 1'b0, 32'h0, 4'hF, 32'h7, 0, 32'hCAFE_F00D, 1'b0);
        stray_ack(32'h5555_AAAA);
        access(BASE + 32'h24, 1'b0, 32'h0, 4'hF, 32'h8, TO, 32'h0BAD_F00D, 1'b0);
        access(BASE + 32'h28, 1'b1, 32'h9999_8888, 4'hC, 32'h9, 0, 32'h0, 1'b0);
        access(BASE + 32'h2C, 1'b0, 32'h0, 4'hF, 32'h1, 1, 32'h7777_6666, 1'b0);

        // Reset in the second REQ cycle abandons the transaction.
        $display("reset during REQ");
        dv = 1'b1; addr = BASE + 32'h30; write = 1'b0;
        @(negedge clk);
        check("mid_hld_c0", hld, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_req_c1", req, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0; dv = 1'b0;
        #1;
        check("mid_req_clr", req, 1'b0);
        check("mid_hld_clr", hld, 1'b0);
        check("mid_addr_clr", req_addr, 10'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        stray_ack(32'h3333_4444);
        access(BASE + 32'h34, 1'b0, 32'h0, 4'hF, 32'h2, 2, 32'h600D_600D, 1'b0);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 9) < 8) begin
                a = BASE + $urandom_range(0, WIN - 1);
            end else begin
                a = $urandom;
                if ((a / WIN) == (BASE / WIN)) a = a ^ 32'h8000_0000;
            end
            d = $urandom;
            access(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom,
                   $urandom_range(0, TO + 2), d, 1'($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i3c_axi_sub_reg_bridge.md
# i3c_axi_sub_reg_bridge

Component-side bridge placed directly downstream of the AXI subordinate's component interface (`dv`/`addr`/`write`/`hld`/`rdata`/`rd_err`/`wr_err`). It converts each single-beat component access into a registered request/acknowledge transaction on a register-window bus that can take a variable number of cycles. While the downstream transaction is in flight, the bridge holds the upstream with `hld`. It also range-checks addresses and bounds every transaction with a timeout.

## Interface
Parameters:
- `AW`, 32: byte address width.
- `DW`, 32: data width; `BC = DW/8`.
- `UW`, 32: user width.
- `IW`, 1: ID width.
- `BASE_ADDR`, 0: byte base of the window; aligned to `WIN_SIZE`.
- `WIN_SIZE`, 4096: window size in bytes; power of two, at least `BC`.
- `TIMEOUT`, 256: maximum number of `REQ` cycles without `ack`; 0 disables the timeout.
- `RAW = $clog2(WIN_SIZE) - $clog2(BC)`: downstream word-address width.

Ports (clock and reset: one clock, asynchronous active-low reset):
- `clk` in 1: clock.
- `rst_n` in 1: async active-low reset.
- `dv` in 1: upstream access valid.
- `addr` in AW: byte address.
- `write` in 1: 1 = write, 0 = read.
- `user` in UW: user sideband.
- `id` in IW: transaction ID (unused, kept for lint).
- `wdata` in DW: write data.
- `wstrb` in BC: write byte strobes.
- `size` in 3: AXI size (unused).
- `last` in 1: burst last (unused).
- `hld` out 1: upstream hold.
- `rdata` out DW: read data, valid on the completion cycle.
- `rd_err` out 1: read error, valid on the completion cycle.
- `wr_err` out 1: write error, valid on the completion cycle.
- `req` out 1: downstream request.
- `req_we` out 1: downstream write enable.
- `req_addr` out RAW: downstream word address.
- `req_wdata` out DW: downstream write data.
- `req_wstrb` out BC: downstream write strobes.
- `req_user` out UW: downstream user sideband.
- `ack` in 1: downstream acknowledge (single-cycle).
- `ack_rdata` in DW: downstream read data, qualified by `ack`.
- `ack_err` in 1: downstream error, qualified by `ack`.
- `timeout_evt` out 1: one-cycle pulse when a transaction times out.

## Operation
- FSM states: `IDLE`, `REQ`, `RESP`. Reset state is `IDLE`.
- In range means `addr[AW-1:$clog2(WIN_SIZE)] == BASE_ADDR[AW-1:$clog2(WIN_SIZE)]`. Offset bits below `$clog2(BC)` are ignored.
- `IDLE`, `dv` = 1 and in range:
  - `hld` = 1, combinational.
  - Capture `write`, the word offset, `wdata`, `wstrb` and `user` into the `req_*` registers.
  - Go to `REQ`.
- `IDLE`, `dv` = 1 and out of range:
  - Same-cycle completion: `hld` = 0, `rdata` = 0.
  - `rd_err` = `!write`, `wr_err` = `write`.
  - No request is issued; stay in `IDLE`.
- `IDLE`, `dv` = 0: `hld` = 0 and all error outputs are 0.
- `REQ`:
  - `req` = 1, `hld` = 1; the timeout counter increments every cycle.
  - `ack` = 1: latch `ack_rdata` (forced to 0 for writes) and `ack_err`; go to `RESP`.
  - `TIMEOUT` != 0, `ack` = 0 and the counter reaches `TIMEOUT`: latch rdata = 0 and err = 1, pulse `timeout_evt`, go to `RESP`.
  - `ack` and the timeout condition in the same cycle: `ack` wins and no timeout is flagged.
- `RESP`:
  - `hld` = 0, `req` = 0.
  - `rdata` = latched data.
  - `rd_err` = latched err & !`req_we`; `wr_err` = latched err & `req_we`.
  - Upstream samples the completion this cycle. Go to `IDLE` unconditionally.
- `ack` outside `REQ` is ignored and has no effect on outputs.
- Upstream holds `dv` and its fields stable while `hld` = 1. The bridge does not re-sample the upstream fields in `REQ` or `RESP`.
- `rdata` is 0 whenever the FSM is not in `RESP`.
- Timeout counter: width `$clog2(TIMEOUT+1)`, saturating. Cleared on entry to `REQ`.

## Timing
- Reset (async assert, sync deassert handled externally) sets:
  - State `IDLE`; `req` = 0; all `req_*` = 0; latched data/err = 0; counter = 0; `timeout_evt` = 0.
  - `hld`, `rdata`, `rd_err` and `wr_err` follow from the `IDLE` rules.
- In-range access latency, measuring `dv` from cycle 0:
  - `req` asserts in cycle 1.
  - With `ack` in cycle k ≥ 1, the completion (`hld` = 0) occurs in cycle k+1.
  - Minimum latency is 2 cycles.
- Out-of-range access: completes in cycle 0.
- Back-to-back: `dv` held after `RESP` starts a new access in the following `IDLE` cycle. Steady-state rate is one access per 3 cycles when `ack` arrives immediately.
- Timeout: with no `ack`, `REQ` occupies cycles 1..`TIMEOUT`, `timeout_evt` pulses in cycle `TIMEOUT`, and `RESP` is in cycle `TIMEOUT`+1.
- Reset asserted mid-`REQ`: `req` drops immediately (async) and the transaction is abandoned. A late `ack` after reset is ignored.

## Test plan
- Read at `BASE_ADDR`+0x10, `ack` in cycle 3 with `ack_rdata` = 0xDEADBEEF -> `req_addr` = 4, `req_we` = 0; completion in cycle 4 with `rdata` = 0xDEADBEEF, `rd_err` = 0.
- Write 0xA5A5A5A5 with `wstrb` = 0x3 at `BASE_ADDR`+0xFFC, `ack_err` = 1 in cycle 1 -> `req_addr` = 0x3FF, `req_wstrb` = 0x3; cycle 2 `wr_err` = 1, `rdata` = 0.
- Read at `BASE_ADDR`+0x1000 (out of range) -> cycle 0: `hld` = 0, `rd_err` = 1, `rdata` = 0, `req` never asserts.
- `TIMEOUT` = 4, read with no `ack` -> `timeout_evt` in cycle 4, cycle 5 `rd_err` = 1 and `rdata` = 0; a late `ack` in cycle 6 is ignored.
- `ack` arriving exactly in cycle `TIMEOUT` -> normal completion with `ack_rdata`, `timeout_evt` = 0.
- `rst_n` low during `REQ` cycle 2 -> `req`, `hld` and the state clear immediately; after release, a new read completes normally.
